mext_issue_ctrl: RTL and testbench
==================================

# mext_issue_ctrl

EX-stage issue and stall controller that sits directly upstream of `M_extend`. It accepts an M-extension instruction from the ID/EX register, latches its operands and destination, and drives `M_extend`'s `ce`. It then stalls the pipeline until `M_extend` reports ready, captures the result, and presents a one-cycle writeback beat. It also covers flush, stale-ready filtering, writes to x0 and a hang watchdog.

## Interface
Parameters:
- `TIMEOUT`, 64, maximum RUN-state cycles before the watchdog fires (must be ≥ 2)
- `CNT_W`, 7, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
- `clk_i`  in  1  single clock, all state on rising edge
- `rst_ni`  in  1  reset, asynchronous, active-low
- `valid_i`  in  1  ID/EX holds a valid instruction
- `instr_id_i`  in  `INST_ID_LEN`  instruction ID from decode
- `rs1_val_i`, `rs2_val_i`  in  `GPR_WIDTH` each  forwarded operands
- `rd_i`  in  5  destination register
- `flush_i`  in  1  kill the in-flight op (branch/trap)
- `wb_stall_i`  in  1  downstream cannot take the writeback beat
- `m_ready_i`  in  1  `ready_o` of `M_extend`
- `m_result_i`  in  `GPR_WIDTH`  `result_o` of `M_extend`
- `m_ce_o`  out  1  clock enable to `M_extend`
- `m_instr_id_o`  out  `INST_ID_LEN`  latched ID to `M_extend`
- `m_rs1_o`, `m_rs2_o`  out  `GPR_WIDTH` each  latched operands to `M_extend`
- `stall_o`  out  1  freeze IF/ID/EX
- `wb_valid_o`  out  1  writeback beat valid
- `wb_rd_o`  out  5  writeback destination
- `wb_data_o`  out  `GPR_WIDTH`  writeback data
- `timeout_o`  out  1  one-cycle pulse when the watchdog fires

## Operation
- M-op: `instr_id_i` ∈ {`MUL_ID`, `MULH_ID`, `MULHSU_ID`, `MULHU_ID`, `DIV_ID`, `DIVU_ID`, `REM_ID`, `REMU_ID`}. Any other ID is ignored, even when `valid_i`=1.
- Reset: state IDLE. All outputs 0, latched ID = `default` (0), counter 0.

States:
- IDLE
  - `accept` = `valid_i` & M-op & !`flush_i`.
  - On `accept` with `rd_i`≠0: latch ID, rs1, rs2, rd; go to ARM.
  - On `accept` with `rd_i`=0: no issue; latch rd; `wb_data`=0; go directly to DONE.
- ARM: one cycle. `m_ce_o`=1. `m_ready_i` is ignored because it may be stale from the previous op. Counter cleared. Go to RUN.
- RUN: `m_ce_o`=1; counter increments each cycle.
  - On `m_ready_i`=1: capture `m_result_i` into `wb_data`; go to DONE.
  - Else, on counter == `TIMEOUT`-1: `timeout_o`=1, `wb_data`=0; go to DONE.
- DONE: `m_ce_o`=0. `wb_valid_o`=1, with `wb_rd_o`/`wb_data_o` stable.
  - If `wb_stall_i`=1: hold DONE.
  - Else: go to IDLE.
  - DONE always lasts ≥1 cycle, which guarantees `ce` is low for ≥1 cycle between ops.

Outputs and priorities:
- `stall_o` = (IDLE & `accept`) | ARM | RUN | (DONE & `wb_stall_i`). It is combinational in IDLE, so the accepting instruction holds in EX.
- `flush_i` has top priority in every state: next state IDLE, `m_ce_o`=0 next cycle, no `wb_valid_o`. In DONE it suppresses `wb_valid_o` in the same cycle (combinational mask).
- While not IDLE, `m_instr_id_o`/`m_rs1_o`/`m_rs2_o` come only from the latch and ignore ID/EX changes. In IDLE they hold their last values.
- No arithmetic is performed here. All width, sign and div-by-zero semantics come from `M_extend`.

## Timing
- Accept at edge T0 → ARM during T0–T1 → RUN from T1.
- Ready seen in RUN cycle k → `wb_valid_o` in the next cycle.
- Minimum issue-to-writeback latency is 3 cycles (ARM, RUN with immediate ready, DONE).
- rd=0 path: accept → DONE next cycle (1 cycle).
- Back-to-back M-ops: a new accept is possible in the cycle after DONE exits, giving throughput of one op per (latency+1) cycles.
- `timeout_o` is asserted in the RUN cycle where the counter hits `TIMEOUT`-1. The DONE beat follows.
- Async reset mid-op: all state clears immediately; `m_ce_o` drops without waiting for the clock.
- `flush_i` and `m_ready_i` in the same RUN cycle: the flush wins and the result is discarded.

## Test plan
- MUL 6 × −7 (0x00000006, 0xFFFFFFF9), rd=5 → `m_ce_o` high ARM..RUN; `wb_valid_o` one cycle with rd 5, data 0xFFFFFFD6; `stall_o` low on that cycle.
- DIV 0x00000064 / 0, with model ready after 33 RUN cycles → `wb_data_o` = result passed through from the model; `stall_o` high throughout; `timeout_o`=0.
- REM with stale `m_ready_i`=1 held high into ARM → not captured in ARM; captured in the first RUN cycle.
- `flush_i` in the 3rd RUN cycle → IDLE next cycle, `m_ce_o`=0, no `wb_valid_o`. A following MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- `wb_stall_i` held 4 cycles in DONE → `wb_valid_o`/`wb_data_o` stable for 5 cycles and `stall_o` high for 4; an M-op on `valid_i` is not accepted until IDLE.
- Model ready tied low, `TIMEOUT`=64 → `timeout_o` pulse on RUN cycle 64, `wb_data_o`=0. A MUL with rd=0 → `m_ce_o` never high; `wb_valid_o` one cycle after accept with data 0.

Source files
------------

// File: rtl/mext_issue_ctrl.sv
// EX-stage issue/stall controller in front of M_extend: latches an M-op, drives ce,
// stalls until ready (or watchdog), then presents a single writeback beat.
module mext_issue_ctrl #(
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned CNT_W       = 7,
  parameter int unsigned INST_ID_LEN = 6,
  parameter int unsigned GPR_WIDTH   = 32,
  parameter logic [INST_ID_LEN-1:0] MUL_ID    = INST_ID_LEN'(1),
  parameter logic [INST_ID_LEN-1:0] MULH_ID   = INST_ID_LEN'(2),
  parameter logic [INST_ID_LEN-1:0] MULHSU_ID = INST_ID_LEN'(3),
  parameter logic [INST_ID_LEN-1:0] MULHU_ID  = INST_ID_LEN'(4),
  parameter logic [INST_ID_LEN-1:0] DIV_ID    = INST_ID_LEN'(5),
  parameter logic [INST_ID_LEN-1:0] DIVU_ID   = INST_ID_LEN'(6),
  parameter logic [INST_ID_LEN-1:0] REM_ID    = INST_ID_LEN'(7),
  parameter logic [INST_ID_LEN-1:0] REMU_ID   = INST_ID_LEN'(8)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   valid_i,
  input  logic [INST_ID_LEN-1:0] instr_id_i,
  input  logic [GPR_WIDTH-1:0]   rs1_val_i,
  input  logic [GPR_WIDTH-1:0]   rs2_val_i,
  input  logic [4:0]             rd_i,
  input  logic                   flush_i,
  input  logic                   wb_stall_i,
  input  logic                   m_ready_i,
  input  logic [GPR_WIDTH-1:0]   m_result_i,
  output logic                   m_ce_o,
  output logic [INST_ID_LEN-1:0] m_instr_id_o,
  output logic [GPR_WIDTH-1:0]   m_rs1_o,
  output logic [GPR_WIDTH-1:0]   m_rs2_o,
  output logic                   stall_o,
  output logic                   wb_valid_o,
  output logic [4:0]             wb_rd_o,
  output logic [GPR_WIDTH-1:0]   wb_data_o,
  output logic                   timeout_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   ce_q;
  logic [INST_ID_LEN-1:0] id_q;
  logic [GPR_WIDTH-1:0]   rs1_q;
  logic [GPR_WIDTH-1:0]   rs2_q;
  logic [4:0]             rd_q;
  logic [GPR_WIDTH-1:0]   data_q;

  logic is_mop;
  logic accept;
  logic hit_last;

  assign is_mop = (instr_id_i == MUL_ID)    || (instr_id_i == MULH_ID)  ||
                  (instr_id_i == MULHSU_ID) || (instr_id_i == MULHU_ID) ||
                  (instr_id_i == DIV_ID)    || (instr_id_i == DIVU_ID)  ||
                  (instr_id_i == REM_ID)    || (instr_id_i == REMU_ID);

  assign accept   = (state == IDLE) && valid_i && is_mop && !flush_i;
  assign hit_last = (cnt == CNT_LAST);

  // Combinational terms: IDLE accept must freeze EX in the same cycle, and flush masks the beat
  assign stall_o    = accept || (state == ARM) || (state == RUN) ||
                      ((state == DONE) && wb_stall_i);
  assign wb_valid_o = (state == DONE) && !flush_i;
  assign timeout_o  = (state == RUN) && !flush_i && !m_ready_i && hit_last;

  assign m_ce_o       = ce_q;
  assign m_instr_id_o = id_q;
  assign m_rs1_o      = rs1_q;
  assign m_rs2_o      = rs2_q;
  assign wb_rd_o      = rd_q;
  assign wb_data_o    = data_q;

  // Issue FSM; ARM exists so a ready left over from the previous op is never sampled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      cnt    <= '0;
      ce_q   <= 1'b0;
      id_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
      data_q <= '0;
    end else if (flush_i) begin
      state <= IDLE;
      ce_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rd_q <= rd_i;
            if (rd_i != 5'd0) begin
              id_q  <= instr_id_i;
              rs1_q <= rs1_val_i;
              rs2_q <= rs2_val_i;
              ce_q  <= 1'b1;
              state <= ARM;
            end else begin
              data_q <= '0;
              state  <= DONE;
            end
          end
        end
        ARM: begin
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (m_ready_i) begin
            data_q <= m_result_i;
            ce_q   <= 1'b0;
            state  <= DONE;
          end else if (hit_last) begin
            data_q <= '0;
            ce_q   <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          if (!wb_stall_i) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          ce_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mext_issue_ctrl.sv
// Scoreboard bench for mext_issue_ctrl: directed ops push expected writebacks,
// a negedge monitor pops and compares every accepted writeback beat.
module tb_mext_issue_ctrl;

  localparam int TIMEOUT = 64;
  localparam logic [5:0] MUL_ID   = 6'd1;
  localparam logic [5:0] MULH_ID  = 6'd2;
  localparam logic [5:0] MULHSU_ID= 6'd3;
  localparam logic [5:0] MULHU_ID = 6'd4;
  localparam logic [5:0] DIV_ID   = 6'd5;
  localparam logic [5:0] DIVU_ID  = 6'd6;
  localparam logic [5:0] REM_ID   = 6'd7;
  localparam logic [5:0] REMU_ID  = 6'd8;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic [5:0]  instr_id_i;
  logic [31:0] rs1_val_i;
  logic [31:0] rs2_val_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        wb_stall_i;
  logic        m_ready_i;
  logic [31:0] m_result_i;
  logic        m_ce_o;
  logic [5:0]  m_instr_id_o;
  logic [31:0] m_rs1_o;
  logic [31:0] m_rs2_o;
  logic        stall_o;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        timeout_o;

  int checks = 0;
  int errors = 0;
  logic [36:0] sb_q[$];

  mext_issue_ctrl #(
    .TIMEOUT(TIMEOUT), .CNT_W(7), .INST_ID_LEN(6), .GPR_WIDTH(32),
    .MUL_ID(MUL_ID), .MULH_ID(MULH_ID), .MULHSU_ID(MULHSU_ID), .MULHU_ID(MULHU_ID),
    .DIV_ID(DIV_ID), .DIVU_ID(DIVU_ID), .REM_ID(REM_ID), .REMU_ID(REMU_ID)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .instr_id_i(instr_id_i),
    .rs1_val_i(rs1_val_i), .rs2_val_i(rs2_val_i), .rd_i(rd_i), .flush_i(flush_i),
    .wb_stall_i(wb_stall_i), .m_ready_i(m_ready_i), .m_result_i(m_result_i),
    .m_ce_o(m_ce_o), .m_instr_id_o(m_instr_id_o), .m_rs1_o(m_rs1_o), .m_rs2_o(m_rs2_o),
    .stall_o(stall_o), .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a beat is consumed when valid and not back-pressured
  always @(negedge clk_i) begin
    if (rst_ni && wb_valid_o && !wb_stall_i) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got rd=%0d data=0x%0h expected no beat at %0t",
                 wb_rd_o, wb_data_o, $time);
      end else begin
        logic [36:0] e;
        e = sb_q.pop_front();
        if ({wb_rd_o, wb_data_o} !== e) begin
          errors++;
          $display("FAIL wb_beat: got rd=%0d data=0x%0h expected rd=%0d data=0x%0h at %0t",
                   wb_rd_o, wb_data_o, e[36:32], e[31:0], $time);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // One M-op: rdy = RUN cycle of ready (0 = never, watchdog), stale = ready high
  // from accept through ARM, hold = DONE cycles with wb_stall_i asserted.
  task automatic do_op(input logic [5:0] id, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res, input int rdy,
                       input bit stale, input int hold);
    logic [31:0] exp_d;
    int n;
    exp_d = (rdy == 0) ? 32'h0 : res;
    n = (rdy == 0) ? TIMEOUT : rdy;
    valid_i = 1'b1; instr_id_i = id; rs1_val_i = a; rs2_val_i = b; rd_i = rd;
    m_ready_i = stale; m_result_i = stale ? 32'hDEADBEEF : 32'h0;
    @(negedge clk_i);
    chk("accept_stall", stall_o, 1);
    chk("accept_ce", m_ce_o, 0);
    sb_q.push_back({rd, exp_d});
    next_cycle();
    valid_i = 1'b0; instr_id_i = 6'd0; rs1_val_i = ~a; rs2_val_i = ~b; rd_i = 5'd0;
    @(negedge clk_i);
    chk("arm_ce", m_ce_o, 1);
    chk("arm_stall", stall_o, 1);
    chk("arm_id", m_instr_id_o, id);
    chk("arm_rs1", m_rs1_o, a);
    chk("arm_rs2", m_rs2_o, b);
    chk("arm_no_wb", wb_valid_o, 0);
    for (int k = 1; k <= n; k++) begin
      next_cycle();
      m_ready_i  = (rdy != 0) && (k == rdy);
      m_result_i = m_ready_i ? res : 32'h0BAD0BAD;
      @(negedge clk_i);
      chk("run_ce", m_ce_o, 1);
      chk("run_stall", stall_o, 1);
      chk("run_timeout", timeout_o, (rdy == 0) && (k == TIMEOUT));
      chk("run_rs1_held", m_rs1_o, a);
    end
    next_cycle();
    m_ready_i = 1'b0; m_result_i = 32'h0; wb_stall_i = (hold > 0);
    if (hold > 0) begin
      valid_i = 1'b1; instr_id_i = MUL_ID; rs1_val_i = 32'd1; rs2_val_i = 32'd1; rd_i = 5'd3;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk_i);
      chk("hold_valid", wb_valid_o, 1);
      chk("hold_data", wb_data_o, exp_d);
      chk("hold_rd", wb_rd_o, rd);
      chk("hold_stall", stall_o, 1);
      chk("hold_ce", m_ce_o, 0);
      next_cycle();
    end
    wb_stall_i = 1'b0; valid_i = 1'b0;
    @(negedge clk_i);
    chk("done_valid", wb_valid_o, 1);
    chk("done_stall", stall_o, 0);
    chk("done_ce", m_ce_o, 0);
    chk("done_timeout", timeout_o, 0);
    next_cycle();
    @(negedge clk_i);
    chk("idle_ce", m_ce_o, 0);
    chk("idle_wb", wb_valid_o, 0);
    chk("idle_stall", stall_o, 0);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL time_limit: got no completion expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    rst_ni = 1'b0; valid_i = 1'b0; instr_id_i = 6'd0; rs1_val_i = 32'd0; rs2_val_i = 32'd0;
    rd_i = 5'd0; flush_i = 1'b0; wb_stall_i = 1'b0; m_ready_i = 1'b0; m_result_i = 32'd0;
    #12;
    chk("rst_ce", m_ce_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_wb", wb_valid_o, 0);
    chk("rst_id", m_instr_id_o, 0);
    chk("rst_data", wb_data_o, 0);
    chk("rst_timeout", timeout_o, 0);
    next_cycle();
    rst_ni = 1'b1;
    next_cycle();

    do_op(MUL_ID,   32'h6,  32'hFFFFFFF9, 5'd5, 32'hFFFFFFD6, 1,  1'b0, 0);
    do_op(DIV_ID,   32'h64, 32'h0,        5'd6, 32'hFFFFFFFF, 33, 1'b0, 0);
    do_op(REM_ID,   32'd17, 32'd5,        5'd8, 32'd2,        1,  1'b1, 0);

    // Flush in RUN cycle 3 together with ready: result must be dropped
    valid_i = 1'b1; instr_id_i = DIVU_ID; rs1_val_i = 32'd100; rs2_val_i = 32'd7; rd_i = 5'd7;
    @(negedge clk_i);
    chk("fl_accept", stall_o, 1);
    next_cycle();
    valid_i = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    flush_i = 1'b1; m_ready_i = 1'b1; m_result_i = 32'h12345678;
    @(negedge clk_i);
    chk("fl_run_ce", m_ce_o, 1);
    chk("fl_no_wb", wb_valid_o, 0);
    next_cycle();
    flush_i = 1'b0; m_ready_i = 1'b0; m_result_i = 32'h0;
    @(negedge clk_i);
    chk("fl_idle_ce", m_ce_o, 0);
    chk("fl_idle_stall", stall_o, 0);
    chk("fl_idle_wb", wb_valid_o, 0);
    next_cycle();

    do_op(MULHU_ID, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 32'hFFFFFFFE, 1, 1'b0, 0);
    do_op(MUL_ID,   32'd3, 32'd4, 5'd9, 32'd12, 2, 1'b0, 4);
    do_op(MUL_ID,   32'd5, 32'd5, 5'd4, 32'd25, 0, 1'b0, 0);

    // rd = x0: no issue, beat of zero one cycle after accept
    valid_i = 1'b1; instr_id_i = MUL_ID; rs1_val_i = 32'd9; rs2_val_i = 32'd9; rd_i = 5'd0;
    @(negedge clk_i);
    chk("x0_accept", stall_o, 1);
    sb_q.push_back({5'd0, 32'd0});
    next_cycle();
    valid_i = 1'b0;
    @(negedge clk_i);
    chk("x0_ce", m_ce_o, 0);
    chk("x0_valid", wb_valid_o, 1);
    chk("x0_data", wb_data_o, 0);
    next_cycle();
    @(negedge clk_i);
    chk("x0_idle_ce", m_ce_o, 0);
    next_cycle();

    // Flush in DONE masks the beat combinationally
    valid_i = 1'b1; instr_id_i = REMU_ID; rd_i = 5'd0;
    next_cycle();
    valid_i = 1'b0; flush_i = 1'b1;
    @(negedge clk_i);
    chk("fd_mask", wb_valid_o, 0);
    next_cycle();
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("fd_idle_wb", wb_valid_o, 0);
    chk("fd_idle_ce", m_ce_o, 0);
    next_cycle();

    // Non-M ID and flushed M-op are both ignored
    valid_i = 1'b1; instr_id_i = 6'd9; rd_i = 5'd5;
    @(negedge clk_i);
    chk("nm_stall", stall_o, 0);
    next_cycle();
    instr_id_i = MUL_ID; flush_i = 1'b1;
    @(negedge clk_i);
    chk("nm_flush_stall", stall_o, 0);
    chk("nm_ce", m_ce_o, 0);
    next_cycle();
    valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    chk("nm_ce2", m_ce_o, 0);
    chk("nm_wb", wb_valid_o, 0);
    next_cycle();

    // Async reset mid-RUN drops ce without a clock edge
    valid_i = 1'b1; instr_id_i = DIV_ID; rs1_val_i = 32'd8; rs2_val_i = 32'd2; rd_i = 5'd2;
    next_cycle();
    valid_i = 1'b0;
    next_cycle();
    @(negedge clk_i);
    chk("ar_run_ce", m_ce_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("ar_ce", m_ce_o, 0);
    chk("ar_stall", stall_o, 0);
    chk("ar_wb", wb_valid_o, 0);
    next_cycle();
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("ar_post_ce", m_ce_o, 0);
    next_cycle();
    next_cycle();

    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
